// File: rtl/lc3_decode_stage_if.sv
// Fetch-to-decode bus: enable, instruction word and PC+1 from the fetch stage.
interface lc3_decode_stage_if #(
   parameter int unsigned INSTR_W = 16
);
   logic               en_decode;
   logic [INSTR_W-1:0] instr_dout;
   logic [INSTR_W-1:0] npc_in;

   // Fetch stage drives the bus
   modport master (
      output en_decode,
      output instr_dout,
      output npc_in
   );

   // Decode stage consumes the bus
   modport slave (
      input en_decode,
      input instr_dout,
      input npc_in
   );
endinterface

// File: rtl/lc3_decode_stage.sv
// LC-3 pipeline decode stage. Registers IR and next-PC and the execute,
// writeback and memory control fields decoded from the incoming instruction.
// Optional macro LC3_DECODE_ILLEGAL_OP_EN flags reserved opcodes on illegal_op.
module lc3_decode_stage #(
   parameter int unsigned          INSTR_W   = 16,
   parameter logic [INSTR_W-1:0]   NPC_RESET = '0
) (
   input  logic               clock,
   input  logic               reset,
   lc3_decode_stage_if.slave  decode_in,
   output logic [INSTR_W-1:0] IR,
   output logic [INSTR_W-1:0] npc_out,
   output logic [5:0]         E_Control,
   output logic [1:0]         W_Control,
   output logic               Mem_Control,
   output logic               decode_valid,
   output logic               illegal_op
);

   localparam logic [3:0] OpBr  = 4'b0000;
   localparam logic [3:0] OpAdd = 4'b0001;
   localparam logic [3:0] OpLd  = 4'b0010;
   localparam logic [3:0] OpSt  = 4'b0011;
   localparam logic [3:0] OpAnd = 4'b0101;
   localparam logic [3:0] OpLdr = 4'b0110;
   localparam logic [3:0] OpStr = 4'b0111;
   localparam logic [3:0] OpNot = 4'b1001;
   localparam logic [3:0] OpLdi = 4'b1010;
   localparam logic [3:0] OpSti = 4'b1011;
   localparam logic [3:0] OpJmp = 4'b1100;
   localparam logic [3:0] OpLea = 4'b1110;

   logic [3:0]         opcode;
   logic [1:0]         alu_control;
   logic [1:0]         pcselect1;
   logic               pcselect2;
   logic               op2select;
   logic [5:0]         e_control_d;
   logic [1:0]         w_control_d;
   logic               mem_control_d;

   logic [INSTR_W-1:0] ir_q;
   logic [INSTR_W-1:0] npc_q;
   logic [5:0]         e_control_q;
   logic [1:0]         w_control_q;
   logic               mem_control_q;
   logic               valid_q;

   assign opcode = decode_in.instr_dout[15:12];

   // Decode control fields straight from the incoming word so they register alongside IR
   always_comb begin
      alu_control   = 2'b00;
      pcselect1     = 2'b00;
      pcselect2     = 1'b0;
      op2select     = 1'b0;
      w_control_d   = 2'b00;
      mem_control_d = 1'b0;
      case (opcode)
         OpAdd: op2select = ~decode_in.instr_dout[5];
         OpAnd: begin
            alu_control = 2'b01;
            op2select   = ~decode_in.instr_dout[5];
         end
         OpNot: begin
            alu_control = 2'b10;
            op2select   = 1'b1;
         end
         OpBr, OpSt: begin
            pcselect1 = 2'b01;
            pcselect2 = 1'b1;
         end
         OpLd: begin
            pcselect1   = 2'b01;
            pcselect2   = 1'b1;
            w_control_d = 2'b01;
         end
         OpLdi: begin
            pcselect1     = 2'b01;
            pcselect2     = 1'b1;
            w_control_d   = 2'b01;
            mem_control_d = 1'b1;
         end
         OpSti: begin
            pcselect1     = 2'b01;
            pcselect2     = 1'b1;
            mem_control_d = 1'b1;
         end
         OpLea: begin
            pcselect1   = 2'b01;
            pcselect2   = 1'b1;
            w_control_d = 2'b10;
         end
         OpJmp: pcselect1 = 2'b11;
         OpLdr: begin
            pcselect1   = 2'b10;
            w_control_d = 2'b01;
         end
         OpStr: pcselect1 = 2'b10;
         // Reserved opcodes (0100, 1000, 1101, 1111) keep all controls zero
         default: ;
      endcase
      e_control_d = {alu_control, pcselect1, pcselect2, op2select};
   end

`ifdef LC3_DECODE_ILLEGAL_OP_EN
   logic is_illegal;
   logic illegal_q;

   assign is_illegal = (opcode == 4'b0100) || (opcode == 4'b1000) ||
                       (opcode == 4'b1101) || (opcode == 4'b1111);

   // Illegal flag follows each capture and holds across stalls
   always_ff @(posedge clock) begin
      if (!reset) begin
         illegal_q <= 1'b0;
      end else if (decode_in.en_decode) begin
         illegal_q <= is_illegal;
      end
   end

   assign illegal_op = illegal_q;
`else
   logic is_illegal;

   assign is_illegal = 1'b0;
   assign illegal_op = 1'b0;
`endif

   // Pipeline register: capture on enable, hold on stall, valid drops when stalled
   always_ff @(posedge clock) begin
      if (!reset) begin
         ir_q          <= '0;
         npc_q         <= NPC_RESET;
         e_control_q   <= '0;
         w_control_q   <= '0;
         mem_control_q <= 1'b0;
         valid_q       <= 1'b0;
      end else if (decode_in.en_decode) begin
         ir_q          <= decode_in.instr_dout;
         npc_q         <= decode_in.npc_in;
         e_control_q   <= e_control_d;
         w_control_q   <= w_control_d;
         mem_control_q <= mem_control_d;
         valid_q       <= ~is_illegal;
      end else begin
         valid_q       <= 1'b0;
      end
   end

   assign IR           = ir_q;
   assign npc_out      = npc_q;
   assign E_Control    = e_control_q;
   assign W_Control    = w_control_q;
   assign Mem_Control  = mem_control_q;
   assign decode_valid = valid_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed self-checking bench for lc3_decode_stage.
module tb_lc3_decode_stage;

   logic        clock;
   logic        reset;
   logic [15:0] IR;
   logic [15:0] npc_out;
   logic [5:0]  E_Control;
   logic [1:0]  W_Control;
   logic        Mem_Control;
   logic        decode_valid;
   logic        illegal_op;

   int checks;
   int errors;

   lc3_decode_stage_if #(.INSTR_W(16)) decode_in ();

   lc3_decode_stage #(
      .INSTR_W   (16),
      .NPC_RESET (16'h0000)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .decode_in    (decode_in),
      .IR           (IR),
      .npc_out      (npc_out),
      .E_Control    (E_Control),
      .W_Control    (W_Control),
      .Mem_Control  (Mem_Control),
      .decode_valid (decode_valid),
      .illegal_op   (illegal_op)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic en, input logic [15:0] instr, input logic [15:0] npc);
      decode_in.en_decode  = en;
      decode_in.instr_dout = instr;
      decode_in.npc_in     = npc;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 16'h1042, 16'h3001);
      tick();
      tick();
      checks++;
      if (IR !== 16'h0000) begin
         errors++; $display("FAIL reset_ir: got %h expected %h", IR, 16'h0000);
      end
      checks++;
      if (npc_out !== 16'h0000) begin
         errors++; $display("FAIL reset_npc: got %h expected %h", npc_out, 16'h0000);
      end
      checks++;
      if ({E_Control, W_Control, Mem_Control, decode_valid, illegal_op} !== 11'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got E=%b W=%b M=%b V=%b I=%b expected all 0",
                  E_Control, W_Control, Mem_Control, decode_valid, illegal_op);
      end
   endtask

   task automatic test_add();
      reset = 1'b1;
      drive(1'b1, 16'h1042, 16'h3001);
      tick();
      checks++;
      if (IR !== 16'h1042 || npc_out !== 16'h3001) begin
         errors++; $display("FAIL add_reg_ir_npc: got %h/%h expected 1042/3001", IR, npc_out);
      end
      checks++;
      if (E_Control !== 6'b000001 || W_Control !== 2'b00 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_reg_ctrl: got E=%b W=%b V=%b expected E=000001 W=00 V=1",
                  E_Control, W_Control, decode_valid);
      end
      drive(1'b1, 16'h1063, 16'h3002);
      tick();
      checks++;
      if (IR !== 16'h1063 || E_Control !== 6'b000000 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL add_imm: got IR=%h E=%b V=%b expected IR=1063 E=000000 V=1",
                  IR, E_Control, decode_valid);
      end
      drive(1'b1, 16'h927F, 16'h3003);
      tick();
      checks++;
      if (E_Control !== 6'b100001 || W_Control !== 2'b00 || Mem_Control !== 1'b0) begin
         errors++;
         $display("FAIL not_ctrl: got E=%b W=%b M=%b expected E=100001 W=00 M=0",
                  E_Control, W_Control, Mem_Control);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] instrs [4];
      logic        exp_m  [4];
      logic [1:0]  exp_w  [4];
      logic [5:0]  exp_e  [4];
      instrs = '{16'hA205, 16'hB402, 16'hE603, 16'h6842};
      exp_m  = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_w  = '{2'b01, 2'b00, 2'b10, 2'b01};
      exp_e  = '{6'b000110, 6'b000110, 6'b000110, 6'b001000};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, instrs[i], 16'h4000 + 16'(i));
         tick();
         checks++;
         if (IR !== instrs[i] || npc_out !== 16'h4000 + 16'(i) || decode_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ir[%0d]: got IR=%h npc=%h V=%b expected IR=%h npc=%h V=1",
                     i, IR, npc_out, decode_valid, instrs[i], 16'h4000 + 16'(i));
         end
         checks++;
         if (E_Control !== exp_e[i] || W_Control !== exp_w[i] || Mem_Control !== exp_m[i]) begin
            errors++;
            $display("FAIL b2b_ctrl[%0d]: got E=%b W=%b M=%b expected E=%b W=%b M=%b",
                     i, E_Control, W_Control, Mem_Control, exp_e[i], exp_w[i], exp_m[i]);
         end
      end
   endtask

   task automatic test_stall();
      drive(1'b1, 16'hC1C0, 16'h5001);
      tick();
      checks++;
      if (IR !== 16'hC1C0 || E_Control !== 6'b001100 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL jmp_capture: got IR=%h E=%b V=%b expected IR=c1c0 E=001100 V=1",
                  IR, E_Control, decode_valid);
      end
      drive(1'b0, 16'h5020, 16'h5002);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (IR !== 16'hC1C0 || npc_out !== 16'h5001 || E_Control !== 6'b001100 ||
             W_Control !== 2'b00 || decode_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got IR=%h npc=%h E=%b W=%b V=%b expected c1c0/5001/001100/00/0",
                     i, IR, npc_out, E_Control, W_Control, decode_valid);
         end
      end
   endtask

   task automatic test_illegal();
      drive(1'b1, 16'hF025, 16'h6001);
      tick();
      checks++;
      if (IR !== 16'hF025 || npc_out !== 16'h6001 || E_Control !== 6'b0 ||
          W_Control !== 2'b0 || Mem_Control !== 1'b0) begin
         errors++;
         $display("FAIL illegal_capture: got IR=%h npc=%h E=%b W=%b M=%b expected f025/6001/0/0/0",
                  IR, npc_out, E_Control, W_Control, Mem_Control);
      end
`ifdef LC3_DECODE_ILLEGAL_OP_EN
      checks++;
      if (illegal_op !== 1'b1 || decode_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_flag: got I=%b V=%b expected I=1 V=0", illegal_op, decode_valid);
      end
      drive(1'b0, 16'h5020, 16'h6002);
      tick();
      checks++;
      if (illegal_op !== 1'b1 || decode_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_hold: got I=%b V=%b expected I=1 V=0", illegal_op, decode_valid);
      end
`else
      checks++;
      if (illegal_op !== 1'b0 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: got I=%b V=%b expected I=0 V=1", illegal_op, decode_valid);
      end
`endif
      drive(1'b1, 16'h5020, 16'h6003);
      tick();
      checks++;
      if (illegal_op !== 1'b0 || E_Control !== 6'b010000 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL and_after_illegal: got I=%b E=%b V=%b expected I=0 E=010000 V=1",
                  illegal_op, E_Control, decode_valid);
      end
   endtask

   task automatic test_reset_mid_stream();
      drive(1'b1, 16'hE603, 16'h7001);
      tick();
      checks++;
      if (W_Control !== 2'b10 || E_Control !== 6'b000110) begin
         errors++;
         $display("FAIL lea_capture: got W=%b E=%b expected W=10 E=000110", W_Control, E_Control);
      end
      reset = 1'b0;
      drive(1'b1, 16'h1042, 16'h7002);
      tick();
      checks++;
      if (IR !== 16'h0 || npc_out !== 16'h0 || E_Control !== 6'b0 || W_Control !== 2'b0 ||
          Mem_Control !== 1'b0 || decode_valid !== 1'b0 || illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got IR=%h npc=%h E=%b W=%b M=%b V=%b I=%b expected all 0",
                  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op);
      end
      // Release reset with enable high: first capture lands one edge later
      reset = 1'b1;
      tick();
      checks++;
      if (IR !== 16'h1042 || npc_out !== 16'h7002 || decode_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_capture: got IR=%h npc=%h V=%b expected 1042/7002/1",
                  IR, npc_out, decode_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      drive(1'b0, 16'h0, 16'h0);
      #1;
      test_reset();
      test_add();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_reset_mid_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
